// File: rtl/tl_timed_cntr_if.sv
// Sensor/freeze inputs and state/dwell outputs of the traffic-light sequencer.
// The controller side (bench or system) uses master; the sequencer uses slave.
interface tl_timed_cntr_if #(
  parameter int TW = 6
);
  logic          Ta;
  logic          Tb;
  logic          hold;
  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic          change;

  modport master (output Ta, Tb, hold, input state, cnt, change);
  modport slave  (input Ta, Tb, hold, output state, cnt, change);
endinterface

// File: rtl/tl_timed_cntr.sv
// Counter-qualified two-road traffic light sequencer: min/max green, fixed
// yellow, demand-driven hand-over, maintenance freeze.
module tl_timed_cntr #(
  parameter int YEL_CYC = 4,
  parameter int MIN_GRN = 8,
  parameter int MAX_GRN = 32,
  parameter int TW      = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  tl_timed_cntr_if.slave bus
);

  typedef enum logic [1:0] {
    S_GA = 2'b11,
    S_YA = 2'b00,
    S_GB = 2'b01,
    S_YB = 2'b10
  } state_t;

  localparam logic [TW-1:0] C_MIN = TW'(MIN_GRN - 1);
  localparam logic [TW-1:0] C_MAX = TW'(MAX_GRN - 1);
  localparam logic [TW-1:0] C_YEL = TW'(YEL_CYC - 1);

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_change;

  state_t        w_next;
  logic          w_exit;
  logic [TW-1:0] w_cnt_inc;

  // Opposite-road demand hands over once min green is met; own-road demand
  // only delays hand-over until max green, which prevents starvation.
  function automatic logic green_exit(input logic [TW-1:0] c,
                                      input logic          opp,
                                      input logic          own);
    return (c >= C_MIN) && opp && (!own || (c == C_MAX));
  endfunction

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] c,
                                            input logic [TW-1:0] lim);
    return (c == lim) ? c : c + 1'b1;
  endfunction

  always_comb begin
    w_exit    = 1'b0;
    w_next    = r_state;
    w_cnt_inc = r_cnt + 1'b1;
    case (r_state)
      S_GA: begin
        w_exit    = green_exit(r_cnt, bus.Tb, bus.Ta);
        w_next    = S_YA;
        w_cnt_inc = sat_inc(r_cnt, C_MAX);
      end
      S_YA: begin
        w_exit = (r_cnt == C_YEL);
        w_next = S_GB;
      end
      S_GB: begin
        w_exit    = green_exit(r_cnt, bus.Ta, bus.Tb);
        w_next    = S_YB;
        w_cnt_inc = sat_inc(r_cnt, C_MAX);
      end
      S_YB: begin
        w_exit = (r_cnt == C_YEL);
        w_next = S_GA;
      end
      default: begin
        w_exit = 1'b1;
        w_next = S_GA;
      end
    endcase
  end

  // Single registered stage: state, dwell count and entry pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_GA;
      r_cnt    <= '0;
      r_change <= 1'b0;
    end else if (bus.hold) begin
      r_change <= 1'b0;
    end else if (w_exit) begin
      r_state  <= w_next;
      r_cnt    <= '0;
      r_change <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_inc;
      r_change <= 1'b0;
    end
  end

  assign bus.state  = r_state;
  assign bus.cnt    = r_cnt;
  assign bus.change = r_change;

endmodule

// File: tb/tb_tl_timed_cntr.sv
// Directed-vector bench for tl_timed_cntr at default timing parameters.
module tb_tl_timed_cntr;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  tl_timed_cntr_if #(.TW(6)) bus ();

  tl_timed_cntr #(
    .YEL_CYC(4), .MIN_GRN(8), .MAX_GRN(32), .TW(6)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released between edges; leaves green A, cnt 0.
  task automatic reset_dut(input logic ta, input logic tb);
    @(negedge clk);
    reset_n  = 1'b0;
    bus.Ta   = ta;
    bus.Tb   = tb;
    bus.hold = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    bus.Ta = 1'b1; bus.Tb = 1'b0; bus.hold = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.state !== 2'b11 || bus.cnt !== 6'd0 || bus.change !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async state=%b cnt=%0d change=%b want 11/0/0",
               bus.state, bus.cnt, bus.change);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (bus.state !== 2'b11 || bus.cnt !== 6'd0 || bus.change !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release state=%b cnt=%0d change=%b want 11/0/0",
               bus.state, bus.cnt, bus.change);
    end
    for (int k = 1; k <= 50; k++) begin
      logic [5:0] e_cnt;
      e_cnt = (k < 31) ? k[5:0] : 6'd31;
      tick();
      n_vec++;
      if (bus.state !== 2'b11 || bus.cnt !== e_cnt || bus.change !== 1'b0) begin
        n_err++;
        $display("FAIL rest k=%0d state=%b cnt=%0d change=%b want 11/%0d/0",
                 k, bus.state, bus.cnt, bus.change, e_cnt);
      end
    end
  endtask

  task automatic test_basic;
    reset_dut(1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      logic [1:0] e_st;
      logic [5:0] e_cnt;
      logic       e_chg;
      if (k < 8)       begin e_st = 2'b11; e_cnt = k[5:0]; end
      else if (k < 12) begin e_st = 2'b00; e_cnt = 6'(k - 8); end
      else             begin e_st = 2'b01; e_cnt = 6'(k - 12); end
      e_chg = (k == 8) || (k == 12);
      tick();
      n_vec++;
      if (bus.state !== e_st || bus.cnt !== e_cnt || bus.change !== e_chg) begin
        n_err++;
        $display("FAIL basic k=%0d state=%b cnt=%0d change=%b want %b/%0d/%b",
                 k, bus.state, bus.cnt, bus.change, e_st, e_cnt, e_chg);
      end
    end
  endtask

  task automatic test_max_green;
    reset_dut(1'b1, 1'b1);
    for (int k = 1; k <= 74; k++) begin
      logic [1:0] e_st;
      int         seg;
      if (k < 32)      begin e_st = 2'b11; seg = 0;  end
      else if (k < 36) begin e_st = 2'b00; seg = 32; end
      else if (k < 68) begin e_st = 2'b01; seg = 36; end
      else if (k < 72) begin e_st = 2'b10; seg = 68; end
      else             begin e_st = 2'b11; seg = 72; end
      tick();
      n_vec++;
      if (bus.state !== e_st || bus.cnt !== 6'(k - seg) ||
          bus.change !== (k == seg)) begin
        n_err++;
        $display("FAIL max_green k=%0d state=%b cnt=%0d change=%b want %b/%0d/%b",
                 k, bus.state, bus.cnt, bus.change, e_st, k - seg, k == seg);
      end
    end
  endtask

  task automatic test_hold;
    reset_dut(1'b0, 1'b1);
    repeat (10) tick();
    n_vec++;
    if (bus.state !== 2'b00 || bus.cnt !== 6'd2) begin
      n_err++;
      $display("FAIL hold_setup state=%b cnt=%0d want 00/2", bus.state, bus.cnt);
    end
    bus.hold = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (bus.state !== 2'b00 || bus.cnt !== 6'd2 || bus.change !== 1'b0) begin
        n_err++;
        $display("FAIL hold_frozen k=%0d state=%b cnt=%0d change=%b want 00/2/0",
                 k, bus.state, bus.cnt, bus.change);
      end
    end
    bus.hold = 1'b0;
    tick();
    n_vec++;
    if (bus.state !== 2'b00 || bus.cnt !== 6'd3 || bus.change !== 1'b0) begin
      n_err++;
      $display("FAIL hold_resume state=%b cnt=%0d change=%b want 00/3/0",
               bus.state, bus.cnt, bus.change);
    end
    tick();
    n_vec++;
    if (bus.state !== 2'b01 || bus.cnt !== 6'd0 || bus.change !== 1'b1) begin
      n_err++;
      $display("FAIL hold_exit state=%b cnt=%0d change=%b want 01/0/1",
               bus.state, bus.cnt, bus.change);
    end
    bus.hold = 1'b1;
    tick();
    n_vec++;
    if (bus.state !== 2'b01 || bus.cnt !== 6'd0 || bus.change !== 1'b0) begin
      n_err++;
      $display("FAIL hold_kills_change state=%b cnt=%0d change=%b want 01/0/0",
               bus.state, bus.cnt, bus.change);
    end
    bus.hold = 1'b0;
    tick();
    n_vec++;
    if (bus.state !== 2'b01 || bus.cnt !== 6'd1 || bus.change !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release_gb state=%b cnt=%0d change=%b want 01/1/0",
               bus.state, bus.cnt, bus.change);
    end
  endtask

  task automatic test_withdrawn;
    reset_dut(1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      bus.Tb = (k == 3);
      n_vec++;
      if (bus.state !== 2'b11 || bus.cnt !== k[5:0] || bus.change !== 1'b0) begin
        n_err++;
        $display("FAIL withdrawn k=%0d state=%b cnt=%0d change=%b want 11/%0d/0",
                 k, bus.state, bus.cnt, bus.change, k);
      end
    end
    bus.Tb = 1'b1;
    tick();
    bus.Tb = 1'b0;
    n_vec++;
    if (bus.state !== 2'b00 || bus.cnt !== 6'd0 || bus.change !== 1'b1) begin
      n_err++;
      $display("FAIL late_demand state=%b cnt=%0d change=%b want 00/0/1",
               bus.state, bus.cnt, bus.change);
    end
  endtask

  task automatic test_reset_mid;
    reset_dut(1'b0, 1'b1);
    repeat (17) tick();
    n_vec++;
    if (bus.state !== 2'b01 || bus.cnt !== 6'd5) begin
      n_err++;
      $display("FAIL mid_setup state=%b cnt=%0d want 01/5", bus.state, bus.cnt);
    end
    #2;
    reset_n = 1'b0;
    bus.Tb  = 1'b0;
    #1;
    n_vec++;
    if (bus.state !== 2'b11 || bus.cnt !== 6'd0 || bus.change !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset state=%b cnt=%0d change=%b want 11/0/0",
               bus.state, bus.cnt, bus.change);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++;
      if (bus.state !== 2'b11 || bus.cnt !== k[5:0] || bus.change !== 1'b0) begin
        n_err++;
        $display("FAIL mid_restart k=%0d state=%b cnt=%0d change=%b want 11/%0d/0",
                 k, bus.state, bus.cnt, bus.change, k);
      end
    end
  endtask

  initial begin
    bus.Ta   = 1'b0;
    bus.Tb   = 1'b0;
    bus.hold = 1'b0;
    test_reset();
    test_basic();
    test_max_green();
    test_hold();
    test_withdrawn();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
